npc_ctrl_exc: RTL and testbench

//  Parametrised next-PC / program-counter unit for the single-cycle MIPS core.

---
 rtl/npc_ctrl_exc.sv | 170 +++++++++++++++++
 tb/tb_npc_ctrl_exc.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/npc_ctrl_exc.sv
// Program-counter unit for the single-cycle MIPS core: next-PC selection, stall,
// exception redirect with EPC capture, eret return and jr target alignment checking.
module npc_ctrl_exc #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VECTOR  = WIDTH'(32'h0000_4180),
  parameter bit               CHECK_ALIGN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       npc_sel,
  input  logic [2:0]       br_cond,
  input  logic             zero,
  input  logic             sign,
  input  logic [31:0]      imout,
  input  logic [WIDTH-1:0] regadd,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             redirect,
  output logic             align_err
);

  localparam logic [2:0] SEL_SEQ  = 3'b000;
  localparam logic [2:0] SEL_BR   = 3'b001;
  localparam logic [2:0] SEL_JMP  = 3'b010;
  localparam logic [2:0] SEL_JR   = 3'b011;

  localparam logic [2:0] BR_BEQ   = 3'b000;
  localparam logic [2:0] BR_BNE   = 3'b001;
  localparam logic [2:0] BR_BLEZ  = 3'b010;
  localparam logic [2:0] BR_BGTZ  = 3'b011;
  localparam logic [2:0] BR_BLTZ  = 3'b100;
  localparam logic [2:0] BR_BGEZ  = 3'b101;

  localparam logic [WIDTH-1:0] PC_STEP  = {{(WIDTH-3){1'b0}}, 3'b100};
  localparam logic [WIDTH-1:0] PC_ZERO  = {WIDTH{1'b0}};

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] epc_r;
  logic             align_err_r;

  logic [WIDTH-1:0] seq_s;
  logic [WIDTH-1:0] br_tgt_s;
  logic [WIDTH-1:0] jmp_tgt_s;
  logic [WIDTH-1:0] flow_pc_s;
  logic             flow_redirect_s;
  logic             taken_s;
  logic             fault_s;
  logic [WIDTH-1:0] next_pc_s;
  logic [WIDTH-1:0] next_epc_s;
  logic             next_align_s;
  logic             redirect_s;
  logic             unused_s;

  function automatic logic branch_taken(input logic [2:0] cond, input logic z, input logic s);
    logic t;
    case (cond)
      BR_BEQ:  t = z;
      BR_BNE:  t = !z;
      BR_BLEZ: t = s | z;
      BR_BGTZ: t = !s & !z;
      BR_BLTZ: t = s;
      BR_BGEZ: t = !s;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] branch_target(input logic [WIDTH-1:0] seq,
                                                     input logic [15:0] off);
    return seq + {{(WIDTH-18){off[15]}}, off, 2'b00};
  endfunction

  // Upper PC bits come from pc+4; the low 28 bits are the word-aligned jump index.
  function automatic logic [WIDTH-1:0] jump_target(input logic [WIDTH-1:0] seq,
                                                   input logic [25:0] idx);
    logic [WIDTH-1:0] t;
    t        = seq;
    t[27:0]  = {idx, 2'b00};
    return t;
  endfunction

  assign unused_s = ^imout[31:26];

  // Target generation, fault detection and next-PC priority selection.
  always_comb begin
    seq_s           = pc_r + PC_STEP;
    br_tgt_s        = branch_target(seq_s, imout[15:0]);
    jmp_tgt_s       = jump_target(seq_s, imout[25:0]);
    taken_s         = branch_taken(br_cond, zero, sign);
    fault_s         = CHECK_ALIGN && (npc_sel == SEL_JR) && (regadd[1:0] != 2'b00) && !stall;
    flow_pc_s       = seq_s;
    flow_redirect_s = 1'b0;
    next_pc_s       = pc_r;
    next_epc_s      = epc_r;
    next_align_s    = 1'b0;
    redirect_s      = 1'b0;

    case (npc_sel)
      SEL_SEQ: begin
        flow_pc_s       = seq_s;
        flow_redirect_s = 1'b0;
      end
      SEL_BR: begin
        flow_pc_s       = taken_s ? br_tgt_s : seq_s;
        flow_redirect_s = taken_s;
      end
      SEL_JMP: begin
        flow_pc_s       = jmp_tgt_s;
        flow_redirect_s = 1'b1;
      end
      SEL_JR: begin
        flow_pc_s       = regadd;
        flow_redirect_s = 1'b1;
      end
      default: begin
        flow_pc_s       = seq_s;
        flow_redirect_s = 1'b0;
      end
    endcase

    // An exception is taken even while the pipeline is stalled.
    if (exc_req) begin
      next_pc_s  = EXC_VECTOR;
      next_epc_s = pc_r;
      redirect_s = 1'b1;
    end else if (stall) begin
      next_pc_s  = pc_r;
      next_epc_s = epc_r;
      redirect_s = 1'b0;
    end else if (eret) begin
      next_pc_s  = epc_r;
      next_epc_s = epc_r;
      redirect_s = 1'b1;
    end else if (fault_s) begin
      next_pc_s    = EXC_VECTOR;
      next_epc_s   = pc_r;
      next_align_s = 1'b1;
      redirect_s   = 1'b1;
    end else begin
      next_pc_s  = flow_pc_s;
      next_epc_s = epc_r;
      redirect_s = flow_redirect_s;
    end
  end

  // PC, EPC and alignment-fault pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      epc_r       <= PC_ZERO;
      align_err_r <= 1'b0;
    end else begin
      pc_r        <= next_pc_s;
      epc_r       <= next_epc_s;
      align_err_r <= next_align_s;
    end
  end

  assign pc        = pc_r;
  assign epc       = epc_r;
  assign align_err = align_err_r;
  assign pc_plus4  = seq_s;
  assign redirect  = redirect_s;

endmodule

// File: tb/tb_npc_ctrl_exc.sv
// Self-checking bench for npc_ctrl_exc: a table of per-cycle vectors with hand-derived
// expected PC/EPC/align_err, queued on drive and compared after the clock edge.
module tb_npc_ctrl_exc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  npc_sel = 3'b000;
  logic [2:0]  br_cond = 3'b000;
  logic        zero = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] imout = 32'h0;
  logic [31:0] regadd = 32'h0;
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic        redirect;
  logic        align_err;

  npc_ctrl_exc dut (
    .clk(clk), .rst(rst), .stall(stall), .npc_sel(npc_sel), .br_cond(br_cond),
    .zero(zero), .sign(sign), .imout(imout), .regadd(regadd), .exc_req(exc_req),
    .eret(eret), .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .redirect(redirect),
    .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall;
    logic [2:0]  sel, cond;
    logic        zero, sign;
    logic [31:0] imout, regadd;
    logic        exc, eret;
    logic        chk_rd, exp_rd;
    logic [31:0] exp_pc, exp_epc;
    logic        exp_al;
  } vec_t;

  typedef struct {
    logic [31:0] pc, epc;
    logic        al;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic r, input logic st, input logic [2:0] sel,
                              input logic [2:0] cond, input logic z, input logic sg,
                              input logic [31:0] im, input logic [31:0] ra, input logic ex,
                              input logic er, input logic cr, input logic rd,
                              input logic [31:0] p, input logic [31:0] ep, input logic al);
    vec_t v;
    v.rst = r; v.stall = st; v.sel = sel; v.cond = cond; v.zero = z; v.sign = sg;
    v.imout = im; v.regadd = ra; v.exc = ex; v.eret = er; v.chk_rd = cr; v.exp_rd = rd;
    v.exp_pc = p; v.exp_epc = ep; v.exp_al = al;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    rst = v.rst; stall = v.stall; npc_sel = v.sel; br_cond = v.cond; zero = v.zero;
    sign = v.sign; imout = v.imout; regadd = v.regadd; exc_req = v.exc; eret = v.eret;
    e.pc = v.exp_pc; e.epc = v.exp_epc; e.al = v.exp_al;
    exp_q.push_back(e);
    #1;
    if (v.chk_rd) check($sformatf("redirect[%0d]", idx), {31'd0, redirect}, {31'd0, v.exp_rd});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("pc[%0d]", idx), pc, e.pc);
    check($sformatf("epc[%0d]", idx), epc, e.epc);
    check($sformatf("align_err[%0d]", idx), {31'd0, align_err}, {31'd0, e.al});
    check($sformatf("pc_plus4[%0d]", idx), pc_plus4, e.pc + 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d done", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    //          rst   stall sel     cond    z     s     imout         regadd        exc   eret  chkrd rd    pc            epc           al
    vecs.push_back(mk(1'b1,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b0,32'h0000_3000,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b1,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b0,32'h0000_3000,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_3004,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_3008,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_300C,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_3010,32'h0000_0000,1'b0));
    // branches from 0x3010
    vecs.push_back(mk(1'b0,1'b0,3'b001,3'b000,1'b1,1'b0,32'h1000_FFFC,32'h0000_0000,1'b0,1'b0,1'b1,1'b1,32'h0000_3004,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b011,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_3010,1'b0,1'b0,1'b1,1'b1,32'h0000_3010,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b001,3'b000,1'b0,1'b0,32'h1000_FFFC,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_3014,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b001,3'b011,1'b0,1'b0,32'h1C00_0004,32'h0000_0000,1'b0,1'b0,1'b1,1'b1,32'h0000_3028,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b001,3'b001,1'b0,1'b0,32'h1400_0002,32'h0000_0000,1'b0,1'b0,1'b1,1'b1,32'h0000_3034,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b001,3'b010,1'b0,1'b1,32'h1800_0001,32'h0000_0000,1'b0,1'b0,1'b1,1'b1,32'h0000_303C,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b001,3'b100,1'b0,1'b0,32'h0400_0010,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_3040,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b001,3'b101,1'b1,1'b0,32'h0401_FFFF,32'h0000_0000,1'b0,1'b0,1'b1,1'b1,32'h0000_3040,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b001,3'b110,1'b1,1'b1,32'h0000_0010,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_3044,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b100,3'b000,1'b1,1'b0,32'h0800_0C40,32'h0000_0003,1'b0,1'b0,1'b1,1'b0,32'h0000_3048,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b111,3'b000,1'b0,1'b0,32'h0800_0C40,32'h0000_0002,1'b0,1'b0,1'b1,1'b0,32'h0000_304C,32'h0000_0000,1'b0));
    // jumps and jr alignment fault
    vecs.push_back(mk(1'b0,1'b0,3'b011,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_3010,1'b0,1'b0,1'b1,1'b1,32'h0000_3010,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b010,3'b000,1'b0,1'b0,32'h0800_0C40,32'h0000_0000,1'b0,1'b0,1'b1,1'b1,32'h0000_3100,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b011,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_3010,1'b0,1'b0,1'b1,1'b1,32'h0000_3010,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b011,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_3202,1'b0,1'b0,1'b1,1'b1,32'h0000_4180,32'h0000_3010,1'b1));
    vecs.push_back(mk(1'b0,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_4184,32'h0000_3010,1'b0));
    // stall, misaligned jr under stall, exception under stall
    vecs.push_back(mk(1'b0,1'b1,3'b010,3'b000,1'b0,1'b0,32'h0800_0C40,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_4184,32'h0000_3010,1'b0));
    vecs.push_back(mk(1'b0,1'b1,3'b010,3'b000,1'b0,1'b0,32'h0800_0C40,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_4184,32'h0000_3010,1'b0));
    vecs.push_back(mk(1'b0,1'b1,3'b011,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_3203,1'b0,1'b0,1'b1,1'b0,32'h0000_4184,32'h0000_3010,1'b0));
    vecs.push_back(mk(1'b0,1'b1,3'b010,3'b000,1'b0,1'b0,32'h0800_0C40,32'h0000_0000,1'b1,1'b0,1'b1,1'b1,32'h0000_4180,32'h0000_4184,1'b0));
    // exception + eret interplay
    vecs.push_back(mk(1'b0,1'b0,3'b011,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_3020,1'b0,1'b0,1'b1,1'b1,32'h0000_3020,32'h0000_4184,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b1,1'b0,1'b1,1'b1,32'h0000_4180,32'h0000_3020,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_4184,32'h0000_3020,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_4188,32'h0000_3020,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b1,1'b1,1'b1,1'b1,32'h0000_4180,32'h0000_4188,1'b0));
    vecs.push_back(mk(1'b0,1'b1,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b1,1'b1,1'b0,32'h0000_4180,32'h0000_4188,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b011,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0001,1'b0,1'b1,1'b1,1'b1,32'h0000_4188,32'h0000_4188,1'b0));
    // jump upper bits from pc+4 and wrap-around
    vecs.push_back(mk(1'b0,1'b0,3'b011,3'b000,1'b0,1'b0,32'h0000_0000,32'hF000_0000,1'b0,1'b0,1'b1,1'b1,32'hF000_0000,32'h0000_4188,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b010,3'b000,1'b0,1'b0,32'h0BFF_FFFF,32'h0000_0000,1'b0,1'b0,1'b1,1'b1,32'hFFFF_FFFC,32'h0000_4188,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_0000,32'h0000_4188,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_0004,32'h0000_4188,1'b0));
    // fault then reset during a second faulting jr
    vecs.push_back(mk(1'b0,1'b0,3'b011,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_3202,1'b0,1'b0,1'b1,1'b1,32'h0000_4180,32'h0000_0004,1'b1));
    vecs.push_back(mk(1'b1,1'b0,3'b011,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_3202,1'b0,1'b0,1'b0,1'b0,32'h0000_3000,32'h0000_0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_3004,32'h0000_0000,1'b0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Back-to-back faults keep align_err high, then it drops on the next clean edge.
    apply(mk(1'b0,1'b0,3'b011,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_3201,1'b0,1'b0,1'b1,1'b1,32'h0000_4180,32'h0000_3004,1'b1), 100);
    apply(mk(1'b0,1'b0,3'b011,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_3203,1'b0,1'b0,1'b1,1'b1,32'h0000_4180,32'h0000_4180,1'b1), 101);
    apply(mk(1'b0,1'b0,3'b000,3'b000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0000_4184,32'h0000_4180,1'b0), 102);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
